// File: rtl/mmio_pkg.sv
// mmio_pkg: register offsets, STATUS bit layout and bus width shared by the MMIO responder.
// Latency: n/a (constants and a pure packing function only).
// Backpressure: n/a.
package mmio_pkg;

  localparam int DATA_W = 32;

  // Word offsets inside the 16-word window (Address[3:0])
  localparam logic [3:0] OFF_LED    = 4'h0;
  localparam logic [3:0] OFF_SW     = 4'h1;
  localparam logic [3:0] OFF_CYCLE  = 4'h2;
  localparam logic [3:0] OFF_TXDATA = 4'h3;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_IE     = 4'h5;

  // STATUS layout: {26'b0, ovf, full, empty, cnt[2:0]}
  localparam int ST_OVF_BIT   = 5;
  localparam int ST_FULL_BIT  = 4;
  localparam int ST_EMPTY_BIT = 3;
  localparam int ST_CNT_W     = 3;

  // The cnt field is fixed at three bits so the flag positions never move;
  // a completely full FIFO is reported through the full flag.
  function automatic logic [DATA_W-1:0] status_word(input logic                ovf,
                                                    input logic                full,
                                                    input logic                empty,
                                                    input logic [ST_CNT_W-1:0] cnt);
    logic [DATA_W-1:0] w;
    w                  = '0;
    w[ST_CNT_W-1:0]    = cnt;
    w[ST_EMPTY_BIT]    = empty;
    w[ST_FULL_BIT]     = full;
    w[ST_OVF_BIT]      = ovf;
    return w;
  endfunction

endpackage

// File: rtl/mmio_sync_fifo.sv
// mmio_sync_fifo: single-clock FIFO with count-based full/empty and power-of-two depth.
// Latency: a pushed word is visible on head_dat the cycle after the push edge.
// Backpressure: push while full and pop while empty are ignored; push and pop may share an edge.
module mmio_sync_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign head_dat = mem_q[rd_ptr_q];

  // Pointer and count update; pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer/count state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: an empty FIFO never presents its contents
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: CPU memory-bus responder for a 16-word window (LED, SW, CYCLE, TXDATA, STATUS).
// Latency: writes act at the sampling edge; reads return one cycle later via rdata_q on Mem_Bus.
// Backpressure: TX FIFO drains on tx_valid & tx_ready; pushes while full are dropped and set ovf.
// Build macro MMIO_IRQ_EN adds the IE register at offset 5 and the registered irq output.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [6:0] BASE_ADDR  = 7'h70,
  parameter int         FIFO_DEPTH = 8,
  parameter int         SW_W       = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CS,
  input  logic              WE,
  input  logic [6:0]        Address,
  inout  wire  [DATA_W-1:0] Mem_Bus,
  output logic              hit,
  input  logic [SW_W-1:0]   sw,
  output logic [15:0]       led,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
`ifdef MMIO_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]        offset;
  logic              wr_en, rd_en;
  logic [DATA_W-1:0] wdat;
  logic [DATA_W-1:0] rd_mux;

  logic [15:0]       led_q, led_d;
  logic [DATA_W-1:0] cyc_q, cyc_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ovf_q, ovf_d;
  logic [SW_W-1:0]   sw_meta_q, sw_meta_d;
  logic [SW_W-1:0]   sw_sync_q, sw_sync_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt;

  // hit already contains CS, so it alone qualifies both bus directions
  assign hit    = CS & (Address[6:4] == BASE_ADDR[6:4]);
  assign offset = Address[3:0];
  assign wr_en  = hit & WE;
  assign rd_en  = hit & ~WE;
  assign wdat   = Mem_Bus;

  // Drive only while the read is still presented; reset releases the bus at once
  assign Mem_Bus = (rd_en & RST) ? rdata_q : {DATA_W{1'bz}};

  assign led       = led_q;
  assign tx_valid  = ~fifo_empty;
  assign fifo_push = wr_en & (offset == OFF_TXDATA);
  assign fifo_pop  = tx_valid & tx_ready;

  mmio_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_tx_fifo (
    .clk      (CLK),
    .rst_n    (RST),
    .push     (fifo_push),
    .push_dat (wdat),
    .pop      (fifo_pop),
    .head_dat (tx_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

`ifdef MMIO_IRQ_EN
  logic [1:0] ie_q, ie_d;
  logic       irq_q, irq_d;
`endif

  // Register read select, evaluated from pre-edge state
  always_comb begin
    rd_mux = '0;
    case (offset)
      OFF_LED:    rd_mux = DATA_W'(led_q);
      OFF_SW:     rd_mux = DATA_W'(sw_sync_q);
      OFF_CYCLE:  rd_mux = cyc_q;
      OFF_STATUS: rd_mux = status_word(ovf_q, fifo_full, fifo_empty, ST_CNT_W'(fifo_cnt));
`ifdef MMIO_IRQ_EN
      OFF_IE:     rd_mux = DATA_W'(ie_q);
`endif
      default:    rd_mux = '0;
    endcase
  end

  // Next-state for LED, cycle counter, overflow flag, switch synchronizer and read data
  always_comb begin
    led_d     = led_q;
    cyc_d     = cyc_q + 32'd1;
    ovf_d     = ovf_q;
    sw_meta_d = sw;
    sw_sync_d = sw_meta_q;
    rdata_d   = rdata_q;
    if (wr_en) begin
      case (offset)
        OFF_LED:    led_d = wdat[15:0];
        OFF_CYCLE:  cyc_d = '0;
        OFF_STATUS: if (wdat[ST_OVF_BIT]) ovf_d = 1'b0;
        default:    ;
      endcase
    end
    // A dropped push is flagged even when a pop frees a slot on the same edge
    if (fifo_push && fifo_full) begin
      ovf_d = 1'b1;
    end
    if (rd_en) begin
      rdata_d = rd_mux;
    end
  end

  // Responder state registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      led_q     <= '0;
      cyc_q     <= '0;
      rdata_q   <= '0;
      ovf_q     <= 1'b0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      led_q     <= led_d;
      cyc_q     <= cyc_d;
      rdata_q   <= rdata_d;
      ovf_q     <= ovf_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end

`ifdef MMIO_IRQ_EN
  // Interrupt enables and the registered interrupt condition
  always_comb begin
    ie_d  = ie_q;
    if (wr_en && (offset == OFF_IE)) begin
      ie_d = wdat[1:0];
    end
    irq_d = (ie_q[0] & fifo_empty) | (ie_q[1] & ovf_q);
  end

  // Interrupt state registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ie_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule
